// File: rtl/capture_pkg.sv
// capture_pkg: shared types and helpers for the capture packer slice.
//   CAPTURE_WORD_W / ADC_W  : packed word and ADC sample widths
//   fifo_entry_t            : one buffered write beat {addr, data}
//   state_e                 : packer FSM states
//   pack_pair()             : sign-extend two ADC samples and pack {B, A}
package capture_pkg;

    localparam int CAPTURE_WORD_W = 32;
    localparam int ADC_W          = 14;
    localparam int FIFO_ENTRY_W   = 2 * CAPTURE_WORD_W;

    typedef struct packed {
        logic [CAPTURE_WORD_W-1:0] addr;
        logic [CAPTURE_WORD_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Each sample is sign-extended to 16 bits; B occupies the upper half.
    function automatic logic [CAPTURE_WORD_W-1:0] pack_pair(
        input logic [ADC_W-1:0] a,
        input logic [ADC_W-1:0] b
    );
        return {{(16-ADC_W){b[ADC_W-1]}}, b, {(16-ADC_W){a[ADC_W-1]}}, a};
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (dropped when full unless popping too)
//   pop        : read request (ignored when empty)
//   full/empty : occupancy flags derived from the registered count
//   dout       : head entry, valid whenever empty=0
module capture_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == {CNT_W{1'b0}});
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop_s  = pop & ~empty;
        // When full, a simultaneous pop frees the slot being written.
        do_push_s = push & (~full | do_pop_s);
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointer and count registers; storage clears so dout reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/capture_packer.sv
// capture_packer: packs A/B sample pairs from the trigger FSM into 32-bit words,
// buffers them and presents byte-addressed write beats on a valid/ready port.
//   clk, rst_n                 : capture clock, asynchronous active-low reset
//   data_in_A/B, write_enable,
//   write_address              : sample strobes from the trigger FSM
//   m_valid/m_ready/m_addr/
//   m_data                     : write beat port to the memory writer
//   frame_done                 : one-cycle pulse once a frame has fully drained
//   word_count                 : accepted beats in current/last frame (saturating)
//   overflow                   : sticky, set when any sample of the frame was dropped
// Optional macro CAPTURE_DROP_COUNT_EN adds drop_count (saturating dropped-sample count).
module capture_packer
    import capture_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] IDX_BASE   = 32'h4000_0000,
    parameter logic [31:0] ADDR_BASE  = 32'h4000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] data_in_A,
    input  logic [ADC_W-1:0] data_in_B,
    input  logic             write_enable,
    input  logic [31:0]      write_address,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_data,
    output logic             frame_done,
    output logic [15:0]      word_count,
    output logic             overflow
`ifdef CAPTURE_DROP_COUNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    state_e      state_q, state_d;
    logic        we_prev_q;
    logic [15:0] word_count_q, word_count_d;
    logic        overflow_q, overflow_d;
    logic        frame_done_q, frame_done_d;
`ifdef CAPTURE_DROP_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;
`endif

    fifo_entry_t entry_s;
    fifo_entry_t fifo_dout_s;
    logic [31:0] idx_off_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        start_s;
    logic        push_req_s;
    logic        push_ok_s;
    logic        pop_s;
    logic        drop_s;

    capture_fifo #(
        .WIDTH (FIFO_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok_s),
        .pop   (pop_s),
        .din   (entry_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .dout  (fifo_dout_s)
    );

    assign m_valid    = ~fifo_empty_s;
    assign m_addr     = fifo_dout_s.addr;
    assign m_data     = fifo_dout_s.data;
    assign frame_done = frame_done_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;
`ifdef CAPTURE_DROP_COUNT_EN
    assign drop_count = drop_count_q;
`endif

    // Entry formation, push/drop decisions and FSM/counter next-state.
    always_comb begin
        // Index-to-byte mapping wraps modulo 2^32.
        idx_off_s     = write_address - IDX_BASE;
        entry_s.addr  = ADDR_BASE + {idx_off_s[29:0], 2'b00};
        entry_s.data  = pack_pair(data_in_A, data_in_B);
        pop_s         = ~fifo_empty_s & m_ready;
        start_s       = (state_q == IDLE) & write_enable & ~we_prev_q;
        push_req_s    = write_enable & (start_s | (state_q == CAPTURE));
        push_ok_s     = push_req_s & (~fifo_full_s | pop_s);
        // Samples arriving after the frame closed are lost as well.
        drop_s        = (push_req_s & ~push_ok_s) | ((state_q == DRAIN) & write_enable);

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_s) state_d = CAPTURE;
                else         state_d = IDLE;
            end
            CAPTURE: begin
                if (!write_enable) state_d = DRAIN;
                else               state_d = CAPTURE;
            end
            DRAIN: begin
                if (fifo_empty_s) state_d = DONE;
                else              state_d = DRAIN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start_s) begin
            word_count_d = 16'd0;
        end else if (pop_s && (word_count_q != 16'hFFFF)) begin
            word_count_d = word_count_q + 16'd1;
        end else begin
            word_count_d = word_count_q;
        end

        if (start_s) begin
            overflow_d = drop_s;
        end else begin
            overflow_d = overflow_q | drop_s;
        end

`ifdef CAPTURE_DROP_COUNT_EN
        if (start_s) begin
            drop_count_d = {15'd0, drop_s};
        end else if (drop_s && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
`endif

        frame_done_d = (state_d == DONE);
    end

    // FSM, status and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_prev_q    <= 1'b0;
            word_count_q <= 16'd0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef CAPTURE_DROP_COUNT_EN
            drop_count_q <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            we_prev_q    <= write_enable;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
`ifdef CAPTURE_DROP_COUNT_EN
            drop_count_q <= drop_count_d;
`endif
        end
    end

endmodule
